// File: rtl/ysyx_24100006_gpr_wb_ctrl.sv
// Write-back arbiter, one-cycle register-file write stage and busy-bit scoreboard for the RV32E GPRs.
// Optional macro GPR_WB_BYPASS_EN forwards the write-stage value to decode sources.
module ysyx_24100006_gpr_wb_ctrl #(
   parameter int unsigned ADDR_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   output logic                  iss_ready,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   output logic                  rs1_stall,
   output logic                  rs2_stall,
   output logic                  rs1_fwd_valid,
   output logic                  rs2_fwd_valid,
   output logic [DATA_WIDTH-1:0] rs1_fwd_data,
   output logic [DATA_WIDTH-1:0] rs2_fwd_data,
   input  logic                  exu_wb_valid,
   output logic                  exu_wb_ready,
   input  logic [ADDR_WIDTH-1:0] exu_wb_rd,
   input  logic [DATA_WIDTH-1:0] exu_wb_data,
   input  logic                  lsu_wb_valid,
   output logic                  lsu_wb_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_wb_rd,
   input  logic [DATA_WIDTH-1:0] lsu_wb_data,
   output logic                  gpr_wen,
   output logic [ADDR_WIDTH-1:0] gpr_waddr,
   output logic [DATA_WIDTH-1:0] gpr_wdata,
   output logic                  sb_err
);

   localparam int unsigned NREG = 1 << ADDR_WIDTH;
   localparam logic [2:0]  LIMIT = 3'(STARVE_LIMIT);

   logic [NREG-1:0]       busy_q, busy_d;
   logic [2:0]            starve_q, starve_d;
   logic                  wb_vld_q, wb_vld_d;
   logic [ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
   logic                  err_q, err_d;

   logic                  exu_gnt, lsu_gnt, hs;
   logic [ADDR_WIDTH-1:0] hs_rd;
   logic [DATA_WIDTH-1:0] hs_data;
   logic                  iss_fire;
   logic                  rs1_hit, rs2_hit;

   // LSU normally wins; a starved EXU takes the port once the counter saturates.
   always_comb begin
      lsu_gnt = lsu_wb_valid && !(exu_wb_valid && (starve_q == LIMIT));
      exu_gnt = exu_wb_valid && !lsu_gnt;
      hs      = exu_gnt || lsu_gnt;
      hs_rd   = lsu_gnt ? lsu_wb_rd   : exu_wb_rd;
      hs_data = lsu_gnt ? lsu_wb_data : exu_wb_data;
   end

   assign exu_wb_ready = exu_gnt;
   assign lsu_wb_ready = lsu_gnt;

   always_comb begin
      starve_d = starve_q;
      if (!exu_wb_valid || exu_gnt) begin
         starve_d = '0;
      end else if (starve_q < LIMIT) begin
         starve_d = starve_q + 3'd1;
      end
   end

   assign iss_ready = !busy_q[iss_rd];
   assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

   assign gpr_wen   = wb_vld_q && (wb_rd_q != '0);
   assign gpr_waddr = wb_rd_q;
   assign gpr_wdata = wb_data_q;
   assign sb_err    = err_q;

   // Clear of the retiring rd and set of a newly issued rd act on distinct
   // registers, since issue is refused while the target is still busy.
   always_comb begin
      busy_d = busy_q;
      if (gpr_wen) begin
         busy_d[wb_rd_q] = 1'b0;
      end
      if (iss_fire) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      wb_vld_d  = hs;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      if (hs) begin
         wb_rd_d   = hs_rd;
         wb_data_d = hs_data;
      end
   end

   assign err_d = err_q || (hs && (hs_rd != '0) && !busy_q[hs_rd]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= '0;
         starve_q  <= '0;
         wb_vld_q  <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         starve_q  <= starve_d;
         wb_vld_q  <= wb_vld_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         err_q     <= err_d;
      end
   end

`ifdef GPR_WB_BYPASS_EN
   assign rs1_hit       = gpr_wen && (wb_rd_q == rs1);
   assign rs2_hit       = gpr_wen && (wb_rd_q == rs2);
   assign rs1_fwd_valid = rs1_hit;
   assign rs2_fwd_valid = rs2_hit;
   assign rs1_fwd_data  = rs1_hit ? wb_data_q : '0;
   assign rs2_fwd_data  = rs2_hit ? wb_data_q : '0;
`else
   assign rs1_hit       = 1'b0;
   assign rs2_hit       = 1'b0;
   assign rs1_fwd_valid = 1'b0;
   assign rs2_fwd_valid = 1'b0;
   assign rs1_fwd_data  = '0;
   assign rs2_fwd_data  = '0;
`endif

   assign rs1_stall = busy_q[rs1] && !rs1_hit;
   assign rs2_stall = busy_q[rs2] && !rs2_hit;

endmodule

// File: tb/tb_ysyx_24100006_gpr_wb_ctrl.sv
module tb_ysyx_24100006_gpr_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [3:0]  iss_rd;
  logic        iss_ready;
  logic [3:0]  rs1, rs2;
  logic        rs1_stall, rs2_stall;
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
  logic        exu_wb_valid, exu_wb_ready;
  logic [3:0]  exu_wb_rd;
  logic [31:0] exu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [3:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        gpr_wen;
  logic [3:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        sb_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_e;
  logic [3:0]  exp_e2;

  always #5 clk = ~clk;

  ysyx_24100006_gpr_wb_ctrl #(
    .ADDR_WIDTH  (4),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .iss_ready    (iss_ready),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_stall    (rs1_stall),
    .rs2_stall    (rs2_stall),
    .rs1_fwd_valid(rs1_fwd_valid),
    .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_data (rs2_fwd_data),
    .exu_wb_valid (exu_wb_valid),
    .exu_wb_ready (exu_wb_ready),
    .exu_wb_rd    (exu_wb_rd),
    .exu_wb_data  (exu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .gpr_wen      (gpr_wen),
    .gpr_waddr    (gpr_waddr),
    .gpr_wdata    (gpr_wdata),
    .sb_err       (sb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    errors++;
    $error("FAIL timeout: stimulus did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst_n        = 1'b0;
    iss_valid    = 1'b0;
    iss_rd       = 4'd5;
    rs1          = 4'd0;
    rs2          = 4'd0;
    exu_wb_valid = 1'b0;
    exu_wb_rd    = 4'd0;
    exu_wb_data  = '0;
    lsu_wb_valid = 1'b0;
    lsu_wb_rd    = 4'd0;
    lsu_wb_data  = '0;
    #2;
    check("rst_wen", gpr_wen, 1'b0);
    check("rst_waddr", gpr_waddr, 4'd0);
    check("rst_wdata", gpr_wdata, 32'd0);
    check("rst_err", sb_err, 1'b0);
    check("rst_iss_ready", iss_ready, 1'b1);
    check("rst_rs1_stall", rs1_stall, 1'b0);
    check("rst_fwd", rs1_fwd_valid, 1'b0);
    tick();
    rst_n = 1'b1;

    tick();
    iss_valid = 1'b1;
    iss_rd    = 4'd5;
    #2;
    check("iss5_ready", iss_ready, 1'b1);
    tick();
    iss_valid = 1'b0;
    rs1       = 4'd5;
    #2;
    check("rs1_5_stall", rs1_stall, 1'b1);
    check("iss5_waw_ready", iss_ready, 1'b0);
    check("rs2_0_stall", rs2_stall, 1'b0);

    tick();
    exu_wb_valid = 1'b1;
    exu_wb_rd    = 4'd5;
    exu_wb_data  = 32'hDEADBEEF;
    #2;
    check("exu5_ready", exu_wb_ready, 1'b1);
    check("exu5_lsu_ready", lsu_wb_ready, 1'b0);
    tick();
    exu_wb_valid = 1'b0;
    #2;
    check("wb5_wen", gpr_wen, 1'b1);
    check("wb5_waddr", gpr_waddr, 4'd5);
    check("wb5_wdata", gpr_wdata, 32'hDEADBEEF);
`ifdef GPR_WB_BYPASS_EN
    check("wb5_stall_byp", rs1_stall, 1'b0);
    check("wb5_fwd_valid", rs1_fwd_valid, 1'b1);
    check("wb5_fwd_data", rs1_fwd_data, 32'hDEADBEEF);
`else
    check("wb5_stall", rs1_stall, 1'b1);
    check("wb5_fwd_valid", rs1_fwd_valid, 1'b0);
    check("wb5_fwd_data", rs1_fwd_data, 32'd0);
`endif
    tick();
    #2;
    check("wb5_n2_wen", gpr_wen, 1'b0);
    check("wb5_n2_stall", rs1_stall, 1'b0);
    check("wb5_n2_iss_ready", iss_ready, 1'b1);
    check("wb5_n2_err", sb_err, 1'b0);

    exp_e = 8'b1000_1000;
    exu_wb_valid = 1'b1;
    lsu_wb_valid = 1'b1;
    exu_wb_rd    = 4'd0;
    lsu_wb_rd    = 4'd0;
    exu_wb_data  = 32'h0000_1234;
    lsu_wb_data  = 32'h0000_1234;
    for (int unsigned i = 0; i < 8; i++) begin
      #2;
      check("arb_exu", exu_wb_ready, exp_e[i]);
      check("arb_lsu", lsu_wb_ready, !exp_e[i]);
      tick();
      #2;
      check("arb_rd0_wen", gpr_wen, 1'b0);
      check("arb_rd0_data", gpr_wdata, 32'h0000_1234);
    end
    for (int unsigned i = 0; i < 2; i++) begin
      #2;
      check("arb_pre_lsu", lsu_wb_ready, 1'b1);
      tick();
    end
    exu_wb_valid = 1'b0;
    #2;
    check("arb_lsu_only", lsu_wb_ready, 1'b1);
    check("arb_lsu_only_exu", exu_wb_ready, 1'b0);
    tick();
    exu_wb_valid = 1'b1;
    exp_e2 = 4'b1000;
    for (int unsigned i = 0; i < 4; i++) begin
      #2;
      check("arb2_exu", exu_wb_ready, exp_e2[i]);
      check("arb2_lsu", lsu_wb_ready, !exp_e2[i]);
      tick();
    end
    exu_wb_valid = 1'b0;
    lsu_wb_valid = 1'b0;
    #2;
    check("rd0_err", sb_err, 1'b0);
    check("rd0_wen", gpr_wen, 1'b0);

    tick();
    iss_valid = 1'b1;
    iss_rd    = 4'd1;
    tick();
    iss_rd    = 4'd2;
    tick();
    iss_valid    = 1'b0;
    exu_wb_valid = 1'b1;
    exu_wb_rd    = 4'd1;
    exu_wb_data  = 32'h0000_0011;
    tick();
    exu_wb_valid = 1'b0;
    lsu_wb_valid = 1'b1;
    lsu_wb_rd    = 4'd2;
    lsu_wb_data  = 32'h0000_0022;
    iss_valid    = 1'b1;
    iss_rd       = 4'd4;
    #2;
    check("b2b_1_waddr", gpr_waddr, 4'd1);
    check("b2b_1_wdata", gpr_wdata, 32'h0000_0011);
    check("b2b_lsu_ready", lsu_wb_ready, 1'b1);
    check("iss4_ready", iss_ready, 1'b1);
    tick();
    lsu_wb_valid = 1'b0;
    iss_valid    = 1'b0;
    rs1          = 4'd4;
    rs2          = 4'd1;
    #2;
    check("b2b_2_wen", gpr_wen, 1'b1);
    check("b2b_2_waddr", gpr_waddr, 4'd2);
    check("b2b_2_wdata", gpr_wdata, 32'h0000_0022);
    check("iss4_stall", rs1_stall, 1'b1);
    check("clr1_stall", rs2_stall, 1'b0);
    tick();
    rs2 = 4'd2;
    #2;
    check("clr2_stall", rs2_stall, 1'b0);
    check("b2b_err", sb_err, 1'b0);

    tick();
    lsu_wb_valid = 1'b1;
    lsu_wb_rd    = 4'd7;
    lsu_wb_data  = 32'h0000_0077;
    #2;
    check("err7_ready", lsu_wb_ready, 1'b1);
    check("err7_err_pre", sb_err, 1'b0);
    tick();
    lsu_wb_valid = 1'b0;
    #2;
    check("err7_wen", gpr_wen, 1'b1);
    check("err7_waddr", gpr_waddr, 4'd7);
    check("err7_err", sb_err, 1'b1);
    tick();
    tick();
    #2;
    check("err7_sticky", sb_err, 1'b1);

    tick();
    iss_valid = 1'b1;
    iss_rd    = 4'd3;
    tick();
    iss_valid    = 1'b0;
    exu_wb_valid = 1'b1;
    exu_wb_rd    = 4'd3;
    exu_wb_data  = 32'hAAAA5555;
    tick();
    exu_wb_valid = 1'b0;
    rs1          = 4'd3;
    rs2          = 4'd4;
    #1;
    check("rst3_wen_pre", gpr_wen, 1'b1);
    check("rst3_stall_pre", rs1_stall | rs1_fwd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst3_wen", gpr_wen, 1'b0);
    check("rst3_waddr", gpr_waddr, 4'd0);
    check("rst3_wdata", gpr_wdata, 32'd0);
    check("rst3_err", sb_err, 1'b0);
    check("rst3_stall", rs1_stall, 1'b0);
    check("rst4_stall", rs2_stall, 1'b0);
    check("rst3_iss_ready", iss_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    tick();
    #2;
    check("rst3_post_wen", gpr_wen, 1'b0);
    tick();
    #2;
    check("rst3_post2_wen", gpr_wen, 1'b0);
    check("rst3_post_err", sb_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_gpr_wb_ctrl.md
# ysyx_24100006_gpr_wb_ctrl

Write-back controller and RAW/WAW scoreboard for the 16×32 RV32E general-purpose register file. It arbitrates the register file's single write port between the EXU and LSU write-back requesters and registers the winner into a one-cycle write stage that drives the register file. It also keeps one busy bit per architectural register, which decode uses to stall on source and destination hazards.

## Interface
- ADDR_WIDTH, 4, register index width (16 registers, x0 hard-wired zero)
- DATA_WIDTH, 32, register data width
- STARVE_LIMIT, 3, consecutive lost EXU arbitration cycles before EXU is forced to win (1..7)

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- iss_valid  in  1  decode issues an instruction writing iss_rd
- iss_rd  in  ADDR_WIDTH  destination of issuing instruction
- iss_ready  out  1  issue permitted (no WAW on iss_rd)
- rs1, rs2  in  ADDR_WIDTH  decode source indices
- rs1_stall, rs2_stall  out  1  source has pending write not yet readable
- rs1_fwd_valid, rs2_fwd_valid  out  1  forward data valid (bypass build only)
- rs1_fwd_data, rs2_fwd_data  out  DATA_WIDTH  forwarded value
- exu_wb_valid / exu_wb_ready  in / out  1  EXU write-back handshake
- exu_wb_rd, exu_wb_data  in  ADDR_WIDTH / DATA_WIDTH  EXU result
- lsu_wb_valid / lsu_wb_ready  in / out  1  LSU write-back handshake
- lsu_wb_rd, lsu_wb_data  in  ADDR_WIDTH / DATA_WIDTH  LSU load result
- gpr_wen, gpr_waddr, gpr_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  register file write port
- sb_err  out  1  sticky: write-back to a register that is not busy

## Operation
- Scoreboard: busy[1..15]. busy[0] is constant 0.
- Issue: iss_ready = !busy[iss_rd], combinational. On iss_valid && iss_ready && iss_rd!=0, busy[iss_rd] is set at the clock edge.
- Arbitration (combinational grant, one winner per cycle):
  - LSU wins if lsu_wb_valid, unless exu_wb_valid && starve_cnt==STARVE_LIMIT. In that case EXU wins.
  - Otherwise EXU wins if exu_wb_valid.
- Ready signals: *_wb_ready equals that requester's grant. A ready is never asserted without the matching valid.
- Starvation counter starve_cnt (3 bits):
  - +1 when exu_wb_valid and EXU is not granted, saturating at STARVE_LIMIT.
  - Cleared when EXU is granted or exu_wb_valid is 0.
- Write stage: on a handshake, {rd, data} are registered. In the next cycle gpr_wen=1 if rd!=0; the stage empties the following cycle unless refilled. rd==0 handshakes are consumed with gpr_wen=0 and no scoreboard effect.
- Busy clear: busy[rd] clears at the edge that ends the write-stage cycle (the same edge at which the register file captures the data).
- Stall: rsN_stall = busy[rsN], except where the bypass build forwards (see Configuration).
- Error: sb_err sets when a handshake carries rd!=0 with busy[rd]==0, and stays set until reset.
- Reset (asynchronous): busy=0, write stage empty, gpr_wen=0, gpr_waddr=0, gpr_wdata=0, starve_cnt=0, sb_err=0.
  - Reset mid-write drops the pending write.
  - All combinational outputs then follow the reset state (iss_ready=1, stalls 0).

## Timing
- Handshake in cycle N → gpr_wen high in cycle N+1 → register readable and busy clear from cycle N+2.
- Throughput: one write-back per cycle. The write stage never back-pressures.
- Issue to rd in cycle N → rs stall visible from cycle N+1.
- Simultaneous issue to rd and busy clear of the same rd cannot occur, because iss_ready is 0 while rd is busy.
- Simultaneous issue to rd A and clear of rd B (A≠B): both take effect.
- Both requesters valid every cycle: EXU wins once after every STARVE_LIMIT LSU wins.

## Configuration
- GPR_WB_BYPASS_EN defined:
  - When the write stage holds a valid write with rd==rsN!=0: rsN_fwd_valid=1, rsN_fwd_data=gpr_wdata, and rsN_stall=0.
  - This allows an issue one cycle earlier.
- GPR_WB_BYPASS_EN undefined:
  - fwd_valid outputs are 0 and fwd_data outputs are 0.
  - rsN_stall is 1 until busy clears.

## Test plan
- Reset, then issue rd=5 → iss_ready stays 1 before issue. Next cycle rs1=5 gives rs1_stall=1; issue to rd=5 again gives iss_ready=0.
- EXU write-back rd=5, data 0xDEADBEEF in cycle N → cycle N+1 shows gpr_wen=1, gpr_waddr=5, gpr_wdata=0xDEADBEEF. In cycle N+2, rs1_stall=0. With bypass, in cycle N+1 rs1_fwd_valid=1, rs1_fwd_data=0xDEADBEEF, rs1_stall=0.
- Both requesters valid continuously (STARVE_LIMIT=3) → grant sequence L,L,L,E,L,L,L,E…, with no simultaneous readies.
- Write-back with rd=0, data 0x1234 → handshake completes, gpr_wen stays 0, busy unchanged, sb_err stays 0.
- Write-back to rd=7 with busy[7]=0 → write performed and sb_err=1 from the next cycle, persisting until rst_n low.
- Pull rst_n low while the write stage is full (rd=3) → gpr_wen=0 immediately, busy[3]=0, and no write to the register file after release.
